// File: rtl/bus_regfile_acc.sv
// Register file plus accumulator joined by an internal bus. Each command is
// sequenced IDLE -> XFER (source onto the bus latch) -> COMMIT (destination update).
module bus_regfile_acc #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Cmd,
  input  logic [AW-1:0]    Addr,
  input  logic [AW-1:0]    SrcAddr,
  inout  wire  [WIDTH-1:0] DioExt,
  output logic             DioOe,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [WIDTH-1:0] AccOut,
  output logic             Zero,
  output logic             Carry
);

  typedef enum logic [2:0] {NOP, WRITE, READ, LDA, STA, ADD, SUB, MOV} cmd_e;
  typedef enum logic [1:0] {IDLE, XFER, COMMIT} state_e;

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  state_e           state, state_next;
  cmd_e             cmd_q;
  logic [AW-1:0]    addr_q, src_q;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] acc, bus, bus_q, addr_data, src_data;
  logic [WIDTH:0]   alu;
  logic             addr_ok, src_ok, bad_addr;

  assign addr_ok  = {1'b0, addr_q} < NREGS_W;
  assign src_ok   = {1'b0, src_q} < NREGS_W;
  assign bad_addr = !addr_ok || (cmd_q == MOV && !src_ok);

  // Out-of-range registers read as zero.
  always_comb begin
    addr_data = '0;
    src_data  = '0;
    if (addr_ok) addr_data = regs[addr_q];
    if (src_ok)  src_data  = regs[src_q];
  end

  always_comb begin
    bus = '0;
    case (cmd_q)
      WRITE:               bus = DioExt;
      READ, LDA, ADD, SUB: bus = addr_data;
      MOV:                 bus = src_data;
      STA:                 bus = acc;
      default:             bus = '0;
    endcase
  end

  // Top bit is the carry for ADD and the borrow for SUB.
  assign alu = (cmd_q == SUB) ? ({1'b0, acc} - {1'b0, bus_q})
                              : ({1'b0, acc} + {1'b0, bus_q});

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = XFER;
      XFER:    state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      cmd_q  <= NOP;
      addr_q <= '0;
      src_q  <= '0;
      bus_q  <= '0;
      acc    <= '0;
      Carry  <= 1'b0;
      Zero   <= 1'b1;
      Done   <= 1'b0;
      Err    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      Done  <= (state == COMMIT);
      Err   <= (state == COMMIT) && bad_addr;
      if (state == IDLE && Start) begin
        cmd_q  <= cmd_e'(Cmd);
        addr_q <= Addr;
        src_q  <= SrcAddr;
      end
      if (state == XFER) bus_q <= bus;
      if (state == COMMIT) begin
        case (cmd_q)
          WRITE, STA, MOV: if (addr_ok) regs[addr_q] <= bus_q;
          LDA: begin
            acc  <= bus_q;
            Zero <= (bus_q == '0);
          end
          ADD, SUB: begin
            acc   <= alu[WIDTH-1:0];
            Carry <= alu[WIDTH];
            Zero  <= (alu[WIDTH-1:0] == '0);
          end
          default: ;
        endcase
      end
    end
  end

  assign Busy   = (state != IDLE);
  assign DioOe  = Busy && (cmd_q == READ);
  assign DioExt = DioOe ? addr_data : 'z;
  assign AccOut = acc;

endmodule

// File: tb/tb_bus_regfile_acc.sv
// Self-checking bench for bus_regfile_acc (NREGS=3 so address 3 is out of range):
// directed literal checks followed by randomized commands against a transaction model.
module tb_bus_regfile_acc;

  localparam int W = 8;
  localparam int N = 3;
  localparam int A = 2;
  localparam logic [2:0] C_NOP = 3'd0, C_WRITE = 3'd1, C_READ = 3'd2, C_LDA = 3'd3,
                         C_STA = 3'd4, C_ADD = 3'd5, C_SUB = 3'd6, C_MOV = 3'd7;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   cmd = '0;
  logic [A-1:0] addr = '0, src_addr = '0;
  logic         tb_oe = 1'b0;
  logic [W-1:0] tb_dval = '0;
  wire  [W-1:0] dio_ext;
  logic         dio_oe, busy, done, err, zero, carry;
  logic [W-1:0] acc_out;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  assign dio_ext = tb_oe ? tb_dval : 'z;

  bus_regfile_acc #(.WIDTH(W), .NREGS(N), .AW(A)) dut (
    .Clock(clock), .Reset(reset), .Start(start), .Cmd(cmd), .Addr(addr),
    .SrcAddr(src_addr), .DioExt(dio_ext), .DioOe(dio_oe), .Busy(busy),
    .Done(done), .Err(err), .AccOut(acc_out), .Zero(zero), .Carry(carry)
  );

  always #5 clock = ~clock;

  // Transaction-level model: a command is accepted, stays busy two cycles,
  // then its whole effect lands at once together with Done/Err.
  int m_regs [4];
  int m_acc, m_age, m_addr, m_src, m_wdata;
  bit m_carry, m_zero, m_active, m_done, m_err, m_bad;
  logic [2:0] m_cmd;

  function automatic int mRead(input int a);
    return (a < N) ? m_regs[a] : 0;
  endfunction

  task automatic mWrite(input int a, input int v);
    if (a < N) m_regs[a] = v;
  endtask

  task automatic mApply();
    int operand;
    operand = mRead(m_addr);
    case (m_cmd)
      C_WRITE: mWrite(m_addr, m_wdata);
      C_STA:   mWrite(m_addr, m_acc);
      C_MOV:   mWrite(m_addr, mRead(m_src));
      C_LDA: begin
        m_acc  = operand;
        m_zero = (m_acc == 0);
      end
      C_ADD: begin
        m_carry = (m_acc + operand) > 255;
        m_acc   = (m_acc + operand) % 256;
        m_zero  = (m_acc == 0);
      end
      C_SUB: begin
        m_carry = m_acc < operand;
        m_acc   = (m_acc - operand + 256) % 256;
        m_zero  = (m_acc == 0);
      end
      default: ;
    endcase
  endtask

  always @(posedge clock) begin
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_acc = 0; m_carry = 0; m_zero = 1;
      m_active = 0; m_done = 0; m_err = 0; m_age = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_active) begin
        m_age++;
        if (m_age == 3) begin
          mApply();
          m_done   = 1;
          m_err    = m_bad;
          m_active = 0;
        end
      end else if (start) begin
        m_active = 1;
        m_age    = 1;
        m_cmd    = cmd;
        m_addr   = int'(addr);
        m_src    = int'(src_addr);
        m_wdata  = int'(tb_dval);
        m_bad    = (m_addr >= N) || (m_cmd == C_MOV && m_src >= N);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("err", 32'(err), 32'(m_err));
      checkOutput("dio_oe", 32'(dio_oe), 32'(m_active && m_cmd == C_READ));
      if (m_active && m_cmd == C_READ) checkOutput("dio_ext", 32'(dio_ext), mRead(m_addr));
      checkOutput("acc", 32'(acc_out), m_acc);
      checkOutput("zero", 32'(zero), 32'(m_zero));
      checkOutput("carry", 32'(carry), 32'(m_carry));
    end
  end

  // Issues one command starting at the current negedge and returns at the
  // negedge of the Done cycle. rst_at 1/2 pulses Reset during XFER/COMMIT.
  task automatic applyStimulus(input logic [2:0] c, input logic [A-1:0] a, input logic [A-1:0] s,
                               input logic [W-1:0] d, input bit junk, input int rst_at,
                               output logic [W-1:0] s_dio, output logic s_oe,
                               output logic s_done, output logic s_err, output logic s_busy);
    start = 1'b1; cmd = c; addr = a; src_addr = s;
    tb_oe = (c == C_WRITE); tb_dval = d;
    @(negedge clock);
    s_dio = dio_ext; s_oe = dio_oe;
    start = junk;
    if (junk) begin
      cmd = 3'($urandom); addr = A'($urandom); src_addr = A'($urandom);
    end
    if (rst_at == 1) reset = 1'b1;
    @(negedge clock);
    reset = (rst_at == 2);
    start = junk;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    s_done = done; s_err = err; s_busy = busy;
  endtask

  initial begin
    logic [W-1:0] sd;
    logic so, sdn, se, sb;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_en = 1'b1;
    checkOutput("rst_acc", 32'(acc_out), 32'h0);
    checkOutput("rst_zero", 32'(zero), 32'h1);
    checkOutput("rst_busy", 32'(busy), 32'h0);

    applyStimulus(C_WRITE, 2'd1, 2'd0, 8'h5A, 0, 0, sd, so, sdn, se, sb);
    applyStimulus(C_READ, 2'd1, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("read_r1_dio", 32'(sd), 32'h5A);
    checkOutput("read_r1_oe", 32'(so), 32'h1);
    checkOutput("read_r1_done", 32'(sdn), 32'h1);
    @(negedge clock);
    checkOutput("oe_released", 32'(dio_oe), 32'h0);

    applyStimulus(C_WRITE, 2'd0, 2'd0, 8'hF0, 0, 0, sd, so, sdn, se, sb);
    applyStimulus(C_WRITE, 2'd2, 2'd0, 8'h20, 0, 0, sd, so, sdn, se, sb);
    applyStimulus(C_LDA, 2'd0, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    applyStimulus(C_ADD, 2'd2, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("add_acc", 32'(acc_out), 32'h10);
    checkOutput("add_carry", 32'(carry), 32'h1);
    checkOutput("add_zero", 32'(zero), 32'h0);
    applyStimulus(C_SUB, 2'd0, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("sub_acc", 32'(acc_out), 32'h20);
    checkOutput("sub_borrow", 32'(carry), 32'h1);

    applyStimulus(C_LDA, 2'd0, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    applyStimulus(C_SUB, 2'd0, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("sub_self_acc", 32'(acc_out), 32'h00);
    checkOutput("sub_self_zero", 32'(zero), 32'h1);
    checkOutput("sub_self_carry", 32'(carry), 32'h0);
    applyStimulus(C_STA, 2'd3, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("sta_oor_err", 32'(se), 32'h1);
    applyStimulus(C_READ, 2'd3, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("read_oor_dio", 32'(sd), 32'h00);
    checkOutput("read_oor_err", 32'(se), 32'h1);

    applyStimulus(C_MOV, 2'd2, 2'd1, 8'h00, 1, 0, sd, so, sdn, se, sb);
    checkOutput("mov_done", 32'(sdn), 32'h1);
    checkOutput("mov_err", 32'(se), 32'h0);
    applyStimulus(C_MOV, 2'd1, 2'd1, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("mov_self_err", 32'(se), 32'h0);
    applyStimulus(C_READ, 2'd2, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("read_r2_mov", 32'(sd), 32'h5A);
    applyStimulus(C_MOV, 2'd0, 2'd3, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("mov_src_oor_err", 32'(se), 32'h1);
    applyStimulus(C_WRITE, 2'd3, 2'd0, 8'h77, 0, 0, sd, so, sdn, se, sb);
    checkOutput("write_oor_err", 32'(se), 32'h1);
    applyStimulus(C_READ, 2'd0, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("read_r0_after_mov", 32'(sd), 32'h00);

    applyStimulus(C_WRITE, 2'd2, 2'd0, 8'hAA, 0, 2, sd, so, sdn, se, sb);
    checkOutput("rst_abort_done", 32'(sdn), 32'h0);
    checkOutput("rst_abort_busy", 32'(sb), 32'h0);
    checkOutput("rst_abort_oe", 32'(dio_oe), 32'h0);
    applyStimulus(C_READ, 2'd2, 2'd0, 8'h00, 0, 0, sd, so, sdn, se, sb);
    checkOutput("rst_abort_r2", 32'(sd), 32'h00);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] c;
      logic [A-1:0] a;
      int rst_at;
      bit junk;
      c = 3'($urandom);
      a = A'($urandom);
      if (c == C_NOP && int'(a) >= N) a = '0;
      rst_at = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 2)) : 0;
      junk = (rst_at == 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(c, a, A'($urandom), 8'($urandom), junk, rst_at, sd, so, sdn, se, sb);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
